// File: rtl/key_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Push-button debouncer. The raw button is synchronised, then a
//             four-state FSM requires DEBOUNCE_CYCLES consecutive stable
//             samples before a press or a release is accepted. Each accepted
//             edge raises a one-cycle strobe.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEBOUNCE_CYCLES  stable cycles needed to accept a press or release
//                     (2 .. 2^32-1)
//    LONG_CYCLES      debounced-hold cycles needed to flag a long press
//                     (2 .. 2^32-1)
//  Ports
//    clk            in   system clock, rising edge
//    rst            in   synchronous reset, active low
//    button         in   raw asynchronous push-button, active high, may bounce
//    level          out  debounced button state (registered)
//    press_pulse    out  one-cycle strobe on an accepted press
//    release_pulse  out  one-cycle strobe on an accepted release
//    long_pulse     out  one-cycle strobe once per press held LONG_CYCLES
//  Build option
//    LONG_PRESS_EN  define to build the long-press hold counter; when left
//                   undefined long_pulse is tied low and no counter exists.
// ============================================================================
module key_debounce #(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd2000000,
  parameter logic [31:0] LONG_CYCLES     = 32'd100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  // Terminal count of the debounce window. The counter starts at zero and
  // stops advancing at this value, so it can never wrap.
  localparam logic [31:0] DEB_LAST = DEBOUNCE_CYCLES - 32'd1;

  // Reject illegal parameter values at elaboration time.
  if ((DEBOUNCE_CYCLES < 32'd2) || (LONG_CYCLES < 32'd2)) begin : g_bad_params
    $error("key_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  // --------------------------------------------------------------------------
  // Two-flop synchronizer. key_s is the only view of the button that the
  // rest of the design is allowed to use.
  // --------------------------------------------------------------------------
  logic sync_ff1;
  logic key_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_ff1 <= 1'b0;
      key_s    <= 1'b0;
    end else begin
      sync_ff1 <= button;
      key_s    <= sync_ff1;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] cnt;
  logic [31:0] cnt_nxt;
  logic        press_nxt;
  logic        release_nxt;
  logic        level_nxt;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (key_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = 32'd0;
        end
      end

      PRESS_WAIT: begin
        // A low sample aborts the window before the terminal compare is
        // considered, so a glitch on the very last cycle is still rejected.
        if (!key_s) begin
          state_nxt = IDLE;
          cnt_nxt   = 32'd0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = 32'd0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end

      PRESSED: begin
        if (!key_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = 32'd0;
        end
      end

      RELEASE_WAIT: begin
        // Returning to PRESSED is silent: the press was already reported.
        if (key_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = 32'd0;
        end else if (cnt == DEB_LAST) begin
          state_nxt   = IDLE;
          cnt_nxt     = 32'd0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 32'd0;
      end
    endcase
  end

  // level follows the state the FSM is entering, so it changes in the same
  // cycle as the matching strobe.
  assign level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 32'd0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      level         <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Long-press detection
  // --------------------------------------------------------------------------
`ifdef LONG_PRESS_EN
  localparam logic [31:0] LONG_LAST = LONG_CYCLES - 32'd1;
  localparam logic [31:0] LONG_PRE  = LONG_CYCLES - 32'd2;

  logic [31:0] hold_cnt;
  logic [31:0] hold_nxt;
  logic        long_nxt;

  // The hold counter advances while PRESSED, freezes through a release
  // window (a release glitch does not restart the hold time) and clears
  // once the button is fully released. It saturates at LONG_LAST, and the
  // strobe fires only on the step into LONG_LAST, so one press can raise
  // long_pulse at most once.
  always_comb begin
    hold_nxt = hold_cnt;
    long_nxt = 1'b0;

    case (state)
      IDLE: begin
        hold_nxt = 32'd0;
      end
      PRESSED: begin
        if (hold_cnt != LONG_LAST) begin
          hold_nxt = hold_cnt + 32'd1;
          long_nxt = (hold_cnt == LONG_PRE);
        end
      end
      default: begin
        hold_nxt = hold_cnt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt   <= 32'd0;
      long_pulse <= 1'b0;
    end else begin
      hold_cnt   <= hold_nxt;
      long_pulse <= long_nxt;
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule
`default_nettype wire
